// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core pipeline.
//   load_type_t : load flavour carried down the pipe (LW..LWR)
//   wb_state_t  : writeback load-wait FSM states
//   REG_ZERO    : architectural $zero register index
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4,
    LWL = 3'd5,
    LWR = 3'd6
  } load_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// load_align: combinational big-endian load-data alignment.
//   i_rdata    : raw memory word (byte k = i_rdata[31-8k -: 8])
//   i_type     : load flavour
//   i_offset   : address[1:0] of the load
//   i_rt_old   : previous rt value, merged by LWL/LWR
//   o_data     : aligned, extended result
//   o_addr_err : misaligned LW/LH/LHU
// Build option: UNALIGNED_LOAD_EN enables LWL/LWR merging; without it
// LWL/LWR decode as plain LW and i_rt_old is ignored.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  load_type_t  i_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rt_old,
  output logic [31:0] o_data,
  output logic        o_addr_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'd0;
    case (i_offset)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword: only offset[1] selects; offset[0] is the error case.
    w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

`ifdef UNALIGNED_LOAD_EN
  logic [4:0]  w_sh_l;
  logic [4:0]  w_sh_r;
  assign w_sh_l = {i_offset, 3'b000};   // 8k
  assign w_sh_r = {~i_offset, 3'b000};  // 8(3-k)
`else
  logic w_unused_rt_old;
  assign w_unused_rt_old = ^i_rt_old;
`endif

  always_comb begin
    o_data     = i_rdata;
    o_addr_err = 1'b0;
    case (i_type)
      LB:  o_data = {{24{w_byte[7]}}, w_byte};
      LBU: o_data = {24'd0, w_byte};
      LH: begin
        o_data     = {{16{w_half[15]}}, w_half};
        o_addr_err = i_offset[0];
      end
      LHU: begin
        o_data     = {16'd0, w_half};
        o_addr_err = i_offset[0];
      end
`ifdef UNALIGNED_LOAD_EN
      LWL: o_data = (i_rdata << w_sh_l) | (i_rt_old & ((32'd1 << w_sh_l) - 32'd1));
      LWR: o_data = (i_rdata >> w_sh_r) | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_r));
`endif
      // LW, and LWL/LWR when unaligned loads are not built in.
      default: o_addr_err = (i_offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, load-response wait FSM and
// register-file write-port driver.
//   clk, reset              : clock, async active-high reset
//   *_m                     : retiring instruction from MEM
//   mem_rdata(_valid)       : data-memory response
//   flush_w                 : squash the instruction entering WB
//   stall_w                 : WB holds a load without data; MEM must hold
//   write_enable/address/data : register-file write port (also forwarded)
//   load_addr_err           : misaligned LW/LH/LHU in WB this cycle
//   load_timeout_err        : sticky, load wait reached LOAD_TIMEOUT
// Build option: UNALIGNED_LOAD_EN (see load_align) enables LWL/LWR.
//
// Handshake: the WB register accepts a new instruction on every edge where
// stall_w=0. stall_w is high exactly while WB holds a valid, well-aligned
// load and mem_rdata_valid is low; the write is presented in the same
// cycle that mem_rdata_valid rises and the next instruction is captured on
// that edge.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  input  logic [2:0]  load_type_m,
  input  logic [1:0]  byte_offset_m,
  input  logic [4:0]  write_reg_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] rt_old_m,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  input  logic        flush_w,
  output logic        stall_w,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic        load_addr_err,
  output logic        load_timeout_err
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  load_type_t        r_load_type;
  logic [1:0]        r_byte_offset;
  logic [4:0]        r_write_reg;
  logic [31:0]       r_alu_result;
  logic [31:0]       r_rt_old;

  wb_state_t         r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_timeout_err;

  logic              w_is_load;
  logic              w_align_err;
  logic [31:0]       w_load_data;

  // MEM/WB register; flush only matters on edges where WB accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_to_reg  <= 1'b0;
      r_load_type   <= LW;
      r_byte_offset <= 2'd0;
      r_write_reg   <= REG_ZERO;
      r_alu_result  <= 32'd0;
      r_rt_old      <= 32'd0;
    end else if (!stall_w) begin
      r_valid       <= valid_m & ~flush_w;
      r_reg_write   <= reg_write_m;
      r_mem_to_reg  <= mem_to_reg_m;
      r_load_type   <= load_type_t'(load_type_m);
      r_byte_offset <= byte_offset_m;
      r_write_reg   <= write_reg_m;
      r_alu_result  <= alu_result_m;
      r_rt_old      <= rt_old_m;
    end
  end

  load_align u_load_align (
    .i_rdata    (mem_rdata),
    .i_type     (r_load_type),
    .i_offset   (r_byte_offset),
    .i_rt_old   (r_rt_old),
    .o_data     (w_load_data),
    .o_addr_err (w_align_err)
  );

  assign w_is_load     = r_valid & r_mem_to_reg;
  assign load_addr_err = w_is_load & w_align_err;
  // A misaligned load is dropped to the exception unit, so it never waits.
  assign stall_w       = w_is_load & ~w_align_err & ~mem_rdata_valid;

  assign write_enable  = r_valid & r_reg_write & (r_write_reg != REG_ZERO) &
                         ~load_addr_err & (~r_mem_to_reg | mem_rdata_valid);
  assign write_address = r_valid ? r_write_reg : REG_ZERO;
  assign write_data    = write_enable ? (r_mem_to_reg ? w_load_data : r_alu_result)
                                      : 32'd0;

  assign load_timeout_err = r_timeout_err;

  // Wait FSM. The counter holds the number of stall cycles already spent,
  // so the IDLE cycle in which the wait begins counts as the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (stall_w) begin
            r_state    <= WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (!stall_w) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == CNT_W'(LOAD_TIMEOUT)) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios for writeback_stage. Inputs are
// driven on the falling edge; combinational outputs are sampled 1ns later.
module tb_writeback_stage;

  localparam int LOAD_TIMEOUT = 255;

  logic        clk;
  logic        reset;
  logic        valid_m;
  logic        reg_write_m;
  logic        mem_to_reg_m;
  logic [2:0]  load_type_m;
  logic [1:0]  byte_offset_m;
  logic [4:0]  write_reg_m;
  logic [31:0] alu_result_m;
  logic [31:0] rt_old_m;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        flush_w;
  logic        stall_w;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        load_addr_err;
  logic        load_timeout_err;

  int checks;
  int errors;

  writeback_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_m          (valid_m),
    .reg_write_m      (reg_write_m),
    .mem_to_reg_m     (mem_to_reg_m),
    .load_type_m      (load_type_m),
    .byte_offset_m    (byte_offset_m),
    .write_reg_m      (write_reg_m),
    .alu_result_m     (alu_result_m),
    .rt_old_m         (rt_old_m),
    .mem_rdata        (mem_rdata),
    .mem_rdata_valid  (mem_rdata_valid),
    .flush_w          (flush_w),
    .stall_w          (stall_w),
    .write_enable     (write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .load_addr_err    (load_addr_err),
    .load_timeout_err (load_timeout_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive_mem(input logic rw, input logic m2r, input logic [2:0] lt,
                           input logic [1:0] off, input logic [4:0] wr,
                           input logic [31:0] alu, input logic [31:0] rt);
    valid_m       = 1'b1;
    reg_write_m   = rw;
    mem_to_reg_m  = m2r;
    load_type_m   = lt;
    byte_offset_m = off;
    write_reg_m   = wr;
    alu_result_m  = alu;
    rt_old_m      = rt;
  endtask

  task automatic clear_mem();
    valid_m       = 1'b0;
    reg_write_m   = 1'b0;
    mem_to_reg_m  = 1'b0;
    load_type_m   = 3'd0;
    byte_offset_m = 2'd0;
    write_reg_m   = 5'd0;
    alu_result_m  = 32'd0;
    rt_old_m      = 32'd0;
  endtask

  task automatic set_rdata(input logic v, input logic [31:0] d);
    mem_rdata_valid = v;
    mem_rdata       = d;
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1;
    flush_w = 1'b0;
    clear_mem();
    set_rdata(1'b0, 32'd0);
    @(negedge clk); #1;
    checks++;
    if ({write_enable, write_address, write_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_port: we=%b wa=%0d wd=%h, required 0/0/0", write_enable, write_address, write_data);
    end
    checks++;
    if ({stall_w, load_addr_err, load_timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: stall/addr/timeout=%b, required 000", {stall_w, load_addr_err, load_timeout_err});
    end
    // An instruction offered while reset is held must not be captured.
    drive_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h1111_2222, 32'd0);
    @(negedge clk); #1;
    checks++;
    if (write_enable !== 1'b0 || write_address !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: we=%b wa=%0d, required 0/0", write_enable, write_address);
    end
    clear_mem();
    reset = 1'b0;
  endtask

  task automatic test_lb_same_cycle();
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd1, 2'd1, 5'd3, 32'd0, 32'd0);
    @(negedge clk); clear_mem(); set_rdata(1'b1, 32'h12F4_5678); #1;
    checks++;
    if (write_data !== 32'hFFFF_FFF4 || write_enable !== 1'b1 || stall_w !== 1'b0 || write_address !== 5'd3) begin
      errors++;
      $display("FAIL lb_off1: wd=%h we=%b stall=%b wa=%0d, required FFFFFFF4/1/0/3", write_data, write_enable, stall_w, write_address);
    end
    @(negedge clk); set_rdata(1'b0, 32'd0);
  endtask

  task automatic test_lhu_delayed();
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd4, 2'd2, 5'd4, 32'd0, 32'd0);
    set_rdata(1'b0, 32'hAAAA_8001);
    @(negedge clk); drive_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd6, 32'h0000_0055, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      checks++;
      if (stall_w !== 1'b1 || write_enable !== 1'b0) begin
        errors++;
        $display("FAIL lhu_wait_%0d: stall=%b we=%b, required 1/0", i, stall_w, write_enable);
      end
    end
    @(negedge clk); set_rdata(1'b1, 32'hAAAA_8001); #1;
    checks++;
    if (stall_w !== 1'b0 || write_enable !== 1'b1 || write_data !== 32'h0000_8001 || write_address !== 5'd4) begin
      errors++;
      $display("FAIL lhu_done: stall=%b we=%b wd=%h wa=%0d, required 0/1/00008001/4", stall_w, write_enable, write_data, write_address);
    end
    @(negedge clk); clear_mem(); set_rdata(1'b0, 32'd0); #1;
    checks++;
    if (write_enable !== 1'b1 || write_address !== 5'd6 || write_data !== 32'h0000_0055) begin
      errors++;
      $display("FAIL lhu_next_captured: we=%b wa=%0d wd=%h, required 1/6/00000055", write_enable, write_address, write_data);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd3, 2'd1, 5'd7, 32'd0, 32'd0);
    set_rdata(1'b0, 32'd0);
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd0, 2'd2, 5'd7, 32'd0, 32'd0); #1;
    checks++;
    if (load_addr_err !== 1'b1 || write_enable !== 1'b0 || stall_w !== 1'b0) begin
      errors++;
      $display("FAIL lh_odd: addr_err=%b we=%b stall=%b, required 1/0/0", load_addr_err, write_enable, stall_w);
    end
    @(negedge clk); clear_mem(); #1;
    checks++;
    if (load_addr_err !== 1'b1 || write_enable !== 1'b0 || stall_w !== 1'b0) begin
      errors++;
      $display("FAIL lw_off2: addr_err=%b we=%b stall=%b, required 1/0/0", load_addr_err, write_enable, stall_w);
    end
    @(negedge clk); #1;
    checks++;
    if (load_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL addr_err_clear: addr_err=%b, required 0", load_addr_err);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); drive_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'd0);
    @(negedge clk); drive_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'hDEAD_BEEF, 32'd0); #1;
    checks++;
    if (write_enable !== 1'b0 || write_data !== 32'd0 || write_address !== 5'd0) begin
      errors++;
      $display("FAIL alu_to_r0: we=%b wd=%h wa=%0d, required 0/00000000/0", write_enable, write_data, write_address);
    end
    @(negedge clk); clear_mem(); #1;
    checks++;
    if (write_enable !== 1'b1 || write_address !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL alu_to_r5: we=%b wa=%0d wd=%h, required 1/5/DEADBEEF", write_enable, write_address, write_data);
    end
  endtask

  task automatic test_flush();
    @(negedge clk); drive_mem(1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'h0000_1234, 32'd0);
    flush_w = 1'b1;
    @(negedge clk); clear_mem(); flush_w = 1'b0; #1;
    checks++;
    if (write_enable !== 1'b0 || write_address !== 5'd0) begin
      errors++;
      $display("FAIL flush: we=%b wa=%0d, required 0/0", write_enable, write_address);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd0, 2'd0, 5'd8, 32'd0, 32'd0);
    set_rdata(1'b0, 32'd0);
    for (int i = 1; i <= LOAD_TIMEOUT + 1; i++) begin
      @(negedge clk);
      if (i == 1) clear_mem();
      #1;
      if (i == LOAD_TIMEOUT + 1) begin
        checks++;
        if (load_timeout_err !== 1'b0 || stall_w !== 1'b1) begin
          errors++;
          $display("FAIL timeout_before: err=%b stall=%b, required 0/1", load_timeout_err, stall_w);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (load_timeout_err !== 1'b1 || stall_w !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rise: err=%b stall=%b we=%b, required 1/1/0", load_timeout_err, stall_w, write_enable);
    end
    @(negedge clk); set_rdata(1'b1, 32'hCAFE_F00D); #1;
    checks++;
    if (write_enable !== 1'b1 || write_data !== 32'hCAFE_F00D || write_address !== 5'd8 || stall_w !== 1'b0) begin
      errors++;
      $display("FAIL late_lw: we=%b wd=%h wa=%0d stall=%b, required 1/CAFEF00D/8/0", write_enable, write_data, write_address, stall_w);
    end
    // New load that will wait; the error must still be set from before.
    @(negedge clk); set_rdata(1'b0, 32'd0);
    drive_mem(1'b1, 1'b1, 3'd2, 2'd3, 5'd10, 32'd0, 32'd0); #1;
    checks++;
    if (load_timeout_err !== 1'b1 || stall_w !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b stall=%b, required 1/0", load_timeout_err, stall_w);
    end
    @(negedge clk); clear_mem();
    @(negedge clk); #2;
    reset = 1'b1; #1;
    checks++;
    if (stall_w !== 1'b0 || load_timeout_err !== 1'b0 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: stall=%b err=%b we=%b, required 0/0/0", stall_w, load_timeout_err, write_enable);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); set_rdata(1'b1, 32'h1234_5678); #1;
    checks++;
    if (write_enable !== 1'b0 || stall_w !== 1'b0) begin
      errors++;
      $display("FAIL response_discarded: we=%b stall=%b, required 0/0", write_enable, stall_w);
    end
    @(negedge clk); set_rdata(1'b0, 32'd0);
  endtask

  task automatic test_unaligned();
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd5, 2'd`ifdef UNALIGNED_LOAD_EN 1 `else 0 `endif, 5'd11, 32'd0, 32'hAABB_CCDD);
    @(negedge clk); drive_mem(1'b1, 1'b1, 3'd6, 2'd1, 5'd12, 32'd0, 32'hAABB_CCDD);
    set_rdata(1'b1, 32'h1122_3344); #1;
`ifdef UNALIGNED_LOAD_EN
    checks++;
    if (write_enable !== 1'b1 || write_data !== 32'h2233_44DD) begin
      errors++;
      $display("FAIL lwl_off1: we=%b wd=%h, required 1/223344DD", write_enable, write_data);
    end
    @(negedge clk); clear_mem(); #1;
    checks++;
    if (write_enable !== 1'b1 || write_data !== 32'hAABB_1122 || load_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL lwr_off1: we=%b wd=%h aerr=%b, required 1/AABB1122/0", write_enable, write_data, load_addr_err);
    end
`else
    checks++;
    if (write_enable !== 1'b1 || write_data !== 32'h1122_3344) begin
      errors++;
      $display("FAIL lwl_as_lw: we=%b wd=%h, required 1/11223344", write_enable, write_data);
    end
    @(negedge clk); clear_mem(); #1;
    checks++;
    if (load_addr_err !== 1'b1 || write_enable !== 1'b0) begin
      errors++;
      $display("FAIL lwr_as_lw_off1: aerr=%b we=%b, required 1/0", load_addr_err, write_enable);
    end
`endif
    @(negedge clk); set_rdata(1'b0, 32'd0);
  endtask

  // Sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lb_same_cycle();
    test_lhu_delayed();
    test_misaligned();
    test_zero_reg();
    test_flush();
    test_unaligned();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the MIPS core: MEM/WB pipeline register, load-data alignment and register-file write-port driver.
- Receives the retiring instruction from the MEM stage and read data from the data-memory interface.
- Waits on multi-cycle load responses with a small FSM, stalling upstream while it waits.
- Drives the register file write port plus a forwarding copy for the hazard unit.

Parameters:
- LOAD_TIMEOUT, 255, wait cycles in WAIT before load_timeout_err asserts; counter width is $clog2(LOAD_TIMEOUT+1).

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- valid_m  input  1  MEM-stage instruction valid
- reg_write_m  input  1  instruction writes a GPR
- mem_to_reg_m  input  1  result comes from memory (load)
- load_type_m  input  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
- byte_offset_m  input  2  address[1:0] of the load
- write_reg_m  input  5  destination register
- alu_result_m  input  32  non-load result
- rt_old_m  input  32  previous rt value, used for the LWL/LWR merge
- mem_rdata  input  32  data-memory read data (big-endian)
- mem_rdata_valid  input  1  mem_rdata valid this cycle
- flush_w  input  1  squash instruction entering WB
- stall_w  output  1  WB cannot accept; MEM must hold
- write_enable  output  1  to register file
- write_address  output  5  to register file
- write_data  output  32  to register file
- load_addr_err  output  1  misaligned LH/LHU/LW detected in WB
- load_timeout_err  output  1  sticky; load wait exceeded LOAD_TIMEOUT

Behaviour:
- Reset:
  - WB register invalid; FSM in IDLE; wait counter 0.
  - Outputs: write_enable 0, write_address 0, write_data 0, stall_w 0, both error flags 0.
- MEM/WB register:
  - Loads on posedge clk when stall_w=0.
  - When flush_w=1, the valid bit loads as 0 and the data fields are don't-care.
  - Holds while stall_w=1; flush_w is ignored while stalled, since MEM holds its instruction.
- FSM states:
  - IDLE: no load pending.
    - A valid load (mem_to_reg=1) in WB with mem_rdata_valid=0 moves to WAIT.
    - With mem_rdata_valid=1, the load completes this cycle with no stall.
  - WAIT: stall_w=1 and the counter increments each cycle.
    - mem_rdata_valid=1 completes the load; the write happens this cycle, stall_w drops, and the FSM returns to IDLE.
    - Counter == LOAD_TIMEOUT sets load_timeout_err (sticky until reset); the FSM stays in WAIT.
- stall_w is combinational: WB holds a valid load and mem_rdata_valid=0.
- Write port (combinational from the WB register and mem_rdata):
  - write_enable = valid & reg_write & (write_reg != 0) & ~load_addr_err & (~load | mem_rdata_valid).
  - write_address = write_reg when the WB register is valid, else 0.
  - write_data is 0 when write_enable=0.
- Write timing: the register file commits on the negative edge in pipelined mode, so the write lands in the same cycle it is presented.
- Load alignment (big-endian; byte k = mem_rdata[31-8k -: 8]):
  - LW: offset must be 0.
  - LB / LBU: selected byte, sign- / zero-extended.
  - LH / LHU: offset 0 → [31:16], offset 2 → [15:0], sign- / zero-extended.
  - LH/LHU with odd offset, or LW with offset ≠ 0: load_addr_err=1 for that cycle, no write, no stall; the exception unit owns recovery.
- Reset mid-WAIT: return to IDLE immediately and drop stall_w; the outstanding response is discarded.
- Simultaneous mem_rdata_valid and a new MEM instruction: the current load writes and the new instruction is captured on the same edge.

Optional Feature:
- Macro: UNALIGNED_LOAD_EN.
- Defined: LWL and LWR are supported, with offset k = byte_offset:
  - LWL = (rdata << 8k) | (rt_old & ((1 << 8k) - 1)).
  - LWR = (rdata >> 8(3-k)) | (rt_old & ~(32'hFFFFFFFF >> 8(3-k))).
- Undefined: load_type 5/6 behave as LW and rt_old_m is unused.

Decomposition:
- Shared package mips_pkg holds:
  - the load_type_t enum (LW..LWR);
  - the wb_state_t enum {IDLE, WAIT};
  - constant REG_ZERO = 5'd0.
- One sub-module, load_align: purely combinational; takes rdata, type, offset and rt_old; returns aligned data and addr_err.

Test Plan:
- Each scenario checks the required response against the stimulus.
- LB, offset 1, mem_rdata=32'h12F45678 valid same cycle → write_data 32'hFFFFFFF4, write_enable 1, stall_w 0.
- LHU, offset 2, rdata=32'hAAAA8001 delayed 3 cycles:
  - stall_w 1 for 3 cycles;
  - write_data 32'h00008001 on the valid cycle;
  - the next instruction is captured on that edge.
- LH, offset 1 → load_addr_err 1, write_enable 0, stall_w 0.
- ALU result 32'hDEADBEEF to $0 → write_enable 0; the same result to $5 → write_enable 1, write_address 5.
- Hold mem_rdata_valid=0 for LOAD_TIMEOUT+1 cycles:
  - load_timeout_err rises and stays high;
  - asserting reset mid-WAIT clears it and drops stall_w asynchronously.
- With UNALIGNED_LOAD_EN defined: LWL, offset 1, rdata=32'h11223344, rt_old=32'hAABBCCDD → write_data 32'h223344DD.
